ps2_mouse_cursor: RTL and testbench

//  Receive-only PS/2 mouse front end. Turns the raw ps2_clk/ps2_data pins into a clamped
//  on-screen cursor position and button levels. Sits upstream of TicTacToe game logic and pixel_Gen,
//  and replaces tmp_FakeMouse on the mouseX/mouseY/mouseBotton nets.

---
 rtl/ps2_mouse_cursor.sv | 145 ++++++++++++++
 tb/tb_ps2_mouse_cursor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_cursor.sv
// Receive-only PS/2 mouse front end: synchronises and filters the PS/2 pins, decodes
// 11-bit frames, assembles 3-byte movement packets and keeps a clamped cursor position.
module ps2_mouse_cursor #(
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479,
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [9:0] xPos,
   output logic [9:0] yPos,
   output logic       btnLeft,
   output logic       btnRight,
   output logic       btnMiddle,
   output logic       packet_valid,
   output logic       rx_error
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          state, stateNext;
   logic            clkS1, clkS2, datS1, datS2;
   logic            filtClk, filtPrev;
   logic [FW-1:0]   filtCnt;
   logic [TW-1:0]   toCnt;
   logic [2:0]      bitCnt;
   logic [7:0]      shiftReg, rxByte, byte1;
   logic            parBit, rxByteVld;
   logic [1:0]      pktIdx;
   logic [6:0]      hdr;  // {yOvf, xOvf, ySign, xSign, M, R, L}
   logic            fall, busy, timeout, rxErr, byteDone;
   logic signed [11:0] dx, dy, nx, ny;
   logic [9:0]      xNext, yNext;

   assign fall    = filtPrev & ~filtClk;
   assign busy    = filtClk & ((state != IDLE) | (pktIdx != 2'd0));
   assign timeout = busy & (toCnt == TW'(TIMEOUT - 1));

   // The fall that leaves IDLE carries the start bit.
   always_comb begin
      stateNext = state;
      rxErr     = 1'b0;
      byteDone  = 1'b0;
      if (timeout)
         stateNext = IDLE;
      else if (fall) begin
         case (state)
            IDLE:   if (datS2) rxErr = 1'b1; else stateNext = DATA;
            DATA:   if (bitCnt == 3'd7) stateNext = PARITY;
            PARITY: stateNext = STOP;
            STOP: begin
               stateNext = IDLE;
               if (!datS2 || !(^{shiftReg, parBit})) rxErr = 1'b1;
               else byteDone = 1'b1;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      dx = hdr[5] ? 12'sd0 : $signed({{3{hdr[3]}}, hdr[3], byte1});
      dy = hdr[6] ? 12'sd0 : $signed({{3{hdr[4]}}, hdr[4], rxByte});
      nx = $signed({2'b00, xPos}) + dx;
      ny = $signed({2'b00, yPos}) - dy;
      xNext = nx[9:0];
      yNext = ny[9:0];
      if (nx < 0)          xNext = 10'd0;
      else if (nx > X_MAX) xNext = 10'(X_MAX);
      if (ny < 0)          yNext = 10'd0;
      else if (ny > Y_MAX) yNext = 10'(Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clkS1 <= 1'b1; clkS2 <= 1'b1; datS1 <= 1'b1; datS2 <= 1'b1;
         filtClk <= 1'b1; filtPrev <= 1'b1; filtCnt <= '0;
         toCnt <= '0; bitCnt <= '0; shiftReg <= '0; parBit <= 1'b0;
         rxByte <= '0; rxByteVld <= 1'b0; rx_error <= 1'b0;
         pktIdx <= '0; hdr <= '0; byte1 <= '0; packet_valid <= 1'b0;
         xPos <= 10'(X_INIT); yPos <= 10'(Y_INIT);
         btnLeft <= 1'b0; btnRight <= 1'b0; btnMiddle <= 1'b0;
      end else begin
         clkS1 <= ps2_clk;  clkS2 <= clkS1;
         datS1 <= ps2_data; datS2 <= datS1;
         filtPrev <= filtClk;
         if (clkS2 != filtClk) begin
            if (filtCnt == FW'(FILTER_LEN - 1)) begin
               filtClk <= clkS2;
               filtCnt <= '0;
            end else
               filtCnt <= filtCnt + 1'b1;
         end else
            filtCnt <= '0;

         if (fall || !busy || timeout) toCnt <= '0;
         else                          toCnt <= toCnt + 1'b1;

         if (state == IDLE) bitCnt <= '0;
         if (fall && state == DATA) begin
            shiftReg <= {datS2, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
         end
         if (fall && state == PARITY) parBit <= datS2;

         rxByteVld <= byteDone;
         if (byteDone) rxByte <= shiftReg;
         rx_error <= rxErr;

         packet_valid <= 1'b0;
         if (rxByteVld) begin
            case (pktIdx)
               2'd0: if (rxByte[3]) begin
                  hdr    <= {rxByte[7:4], rxByte[2:0]};
                  pktIdx <= 2'd1;
               end
               2'd1: begin
                  byte1  <= rxByte;
                  pktIdx <= 2'd2;
               end
               default: begin
                  xPos <= xNext;
                  yPos <= yNext;
                  btnLeft <= hdr[0]; btnRight <= hdr[1]; btnMiddle <= hdr[2];
                  packet_valid <= 1'b1;
                  pktIdx <= 2'd0;
               end
            endcase
         end
         if (rxErr || timeout) pktIdx <= 2'd0;
      end
   end
endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Bench for ps2_mouse_cursor: drives PS/2 frames on the pins and scores each packet_valid
// against expected cursor/button values queued when the packet was sent.
module tb_ps2_mouse_cursor;
   localparam int HALF = 20;   // clk cycles per PS/2 clock phase
   localparam int GAP  = 40;   // idle cycles between bytes
   localparam int TO   = 500;
   localparam int LAT  = 12;   // stop-bit pin fall to packet_valid, in clk edges

   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [9:0] xPos, yPos;
   logic btnLeft, btnRight, btnMiddle, packet_valid, rx_error;

   ps2_mouse_cursor #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .xPos(xPos), .yPos(yPos), .btnLeft(btnLeft), .btnRight(btnRight),
      .btnMiddle(btnMiddle), .packet_valid(packet_valid), .rx_error(rx_error));

   always #5 clk = ~clk;

   typedef struct { logic [9:0] x, y; logic [2:0] btn; } exp_t;
   typedef struct { logic [7:0] b0, b1, b2; logic [9:0] x, y; logic [2:0] btn; } vec_t;

   exp_t expQ[$];
   int tests = 0, fails = 0, expPv = 0;
   int cyc = 0, stopCyc = 0, pvCount = 0, errCount = 0, lat = 0;
   logic [9:0] snapX = '0, snapY = '0;
   logic [2:0] snapBtn = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (packet_valid) begin
         pvCount <= pvCount + 1;
         snapX <= xPos; snapY <= yPos;
         snapBtn <= {btnMiddle, btnRight, btnLeft};
         lat <= cyc - stopCyc;
      end
      if (rx_error) errCount <= errCount + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] d, input bit badPar, input bit badStop);
      logic [10:0] bits;
      bits = {~badStop, (~^d) ^ badPar, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk) ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) stopCyc = cyc;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic checkPacket(input string name);
      exp_t e;
      for (int k = 0; k < 300 && pvCount < expPv; k++) @(negedge clk);
      @(negedge clk);
      chk({name, "_pvcount"}, pvCount, expPv);
      if (expQ.size() == 0) begin
         tests++; fails++;
         $display("FAIL %s_queue: scoreboard empty", name);
      end else begin
         e = expQ.pop_front();
         chk({name, "_x"}, snapX, e.x);
         chk({name, "_y"}, snapY, e.y);
         chk({name, "_btn"}, snapBtn, e.btn);
         chk({name, "_lat"}, lat, LAT);
      end
   endtask

   task automatic sendPacket(input string name, input logic [7:0] b0, b1, b2,
                             input logic [9:0] x, y, input logic [2:0] btn);
      exp_t e;
      e.x = x; e.y = y; e.btn = btn;
      expQ.push_back(e);
      expPv++;
      sendByte(b0, 0, 0); sendByte(b1, 0, 0); sendByte(b2, 0, 0);
      checkPacket(name);
   endtask

   vec_t vecs[18];

   initial begin
      //           b0     b1     b2     x    y    {M,R,L}
      vecs[0]  = '{8'h09, 8'h05, 8'h00, 325, 240, 3'b001};
      vecs[1]  = '{8'h08, 8'h00, 8'h10, 325, 224, 3'b000};
      vecs[2]  = '{8'h28, 8'h00, 8'hF0, 325, 240, 3'b000};
      vecs[3]  = '{8'h0E, 8'h00, 8'h00, 325, 240, 3'b110};
      vecs[4]  = '{8'h08, 8'h00, 8'h80, 325, 112, 3'b000};
      vecs[5]  = '{8'h08, 8'h00, 8'h7F, 325,   0, 3'b000};
      vecs[6]  = '{8'h28, 8'h00, 8'h00, 325, 256, 3'b000};
      vecs[7]  = '{8'h28, 8'h00, 8'h00, 325, 479, 3'b000};
      vecs[8]  = '{8'h18, 8'h00, 8'h00,  69, 479, 3'b000};
      vecs[9]  = '{8'h18, 8'h80, 8'h00,   0, 479, 3'b000};
      vecs[10] = '{8'h18, 8'hF6, 8'h00,   0, 479, 3'b000};
      vecs[11] = '{8'h08, 8'hFF, 8'h00, 255, 479, 3'b000};
      vecs[12] = '{8'h08, 8'hFF, 8'h00, 510, 479, 3'b000};
      vecs[13] = '{8'h08, 8'h7D, 8'h00, 635, 479, 3'b000};
      vecs[14] = '{8'h08, 8'h0A, 8'h00, 639, 479, 3'b000};
      vecs[15] = '{8'h48, 8'h7F, 8'h00, 639, 479, 3'b000};
      vecs[16] = '{8'h88, 8'h00, 8'h10, 639, 479, 3'b000};
      vecs[17] = '{8'h18, 8'hFF, 8'h05, 638, 474, 3'b000};

      repeat (5) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (packet_valid || rx_error) begin
            tests++; fails++;
            $display("FAIL idle_pulse: pv=%0b err=%0b, expected 0", packet_valid, rx_error);
         end
      end
      chk("reset_x", xPos, 320);
      chk("reset_y", yPos, 240);
      chk("reset_btn", {btnMiddle, btnRight, btnLeft}, 0);
      chk("reset_pv", pvCount, 0);
      chk("reset_err", errCount, 0);

      for (int i = 0; i < 18; i++)
         sendPacket($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                    vecs[i].x, vecs[i].y, vecs[i].btn);
      chk("vec_noerr", errCount, 0);

      // Parity error on byte1 restarts packet assembly.
      sendByte(8'h09, 0, 0);
      sendByte(8'h33, 1, 0);
      chk("par_err", errCount, 1);
      chk("par_x", xPos, 638);
      sendPacket("after_par", 8'h1A, 8'hFE, 8'h00, 636, 474, 3'b010);

      sendByte(8'h08, 0, 1);
      chk("frame_err", errCount, 2);
      sendPacket("after_frame", 8'h08, 8'h01, 8'h00, 637, 474, 3'b000);

      sendByte(8'h00, 0, 0);
      chk("resync_pv", pvCount, expPv);
      sendPacket("resync", 8'h08, 8'h01, 8'h00, 638, 474, 3'b000);

      // Partial packet abandoned by timeout.
      sendByte(8'h09, 0, 0);
      sendByte(8'h50, 0, 0);
      repeat (TO + 200) @(negedge clk);
      chk("to_noerr", errCount, 2);
      sendPacket("timeout", 8'h18, 8'hFC, 8'h00, 634, 474, 3'b000);

      // Reset in the middle of a packet.
      sendByte(8'h09, 0, 0);
      sendByte(8'h05, 0, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_x", xPos, 320);
      chk("midrst_y", yPos, 240);
      sendPacket("after_rst", 8'h09, 8'h05, 8'h00, 325, 240, 3'b001);

      repeat (50) @(negedge clk);
      chk("final_pv", pvCount, expPv);
      chk("final_err", errCount, 2);
      chk("final_queue", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
